conveer_stage_responder: RTL
============================

// Module: conveer_stage_responder
// PURPOSE
//  Receiving end of the conveer stage-strobe interface. Tracks the 6-state stage
//  sequence (IF_ID, ID_EX, EX_MEM, MEM_WB, WRITE, LOAD_PC) in lockstep with the
//  control FSM, acknowledges each accepted strobe and owns the PC register.
//  Also counts retired instructions and flags any protocol violation.
// PARAMETERS
//  WIDTH               32  PC width
//  INSTRUCTION_NUMBERS 16  program length; PC advance allowed only while pc < this
//  CNT_WIDTH           16  retired-instruction counter width
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          reset, asynchronous, active-high
//  is_IFID_open   in   1          stage strobe IF_ID
//  is_IDEX_open   in   1          stage strobe ID_EX
//  is_EXMEM_open  in   1          stage strobe EX_MEM
//  is_MEMWB_open  in   1          stage strobe MEM_WB
//  is_load_PC     in   1          PC load request (LOAD_PC state only)
//  pc             out  WIDTH      current PC; drive to control FSM curr_inst
//  stage_ack      out  4          [0]=IFID..[3]=MEMWB, 1-cycle registered pulse
//  expect_state   out  3          expected state: 0..5 = IF_ID..LOAD_PC
//  retired_cnt    out  CNT_WIDTH  accepted MEM_WB strobes, saturating
//  halted         out  1          registered, 1 when pc >= INSTRUCTION_NUMBERS
//  proto_err      out  1          sticky protocol error
//  err_state      out  3          expect_state when first error was detected
// BEHAVIOUR
//  Reset: pc=0, stage_ack=0, expect_state=0, retired_cnt=0, halted=0, proto_err=0,
//   err_state=0. Reset mid-operation aborts the sequence immediately.
//  Sampling: one state per clock; all inputs sampled at each rising clk edge.
//  Legal input per expect_state E:
//   E=0..3: exactly the matching open strobe high; other strobes and is_load_PC low.
//   E=4 (WRITE): all five inputs low.
//   E=5 (LOAD_PC): all open strobes low; is_load_PC == (pc < INSTRUCTION_NUMBERS).
//  Legal cycle: expect_state <= (E==5)?0:E+1. If E<=3, stage_ack[E] is high the next
//   cycle only. If E==3, retired_cnt += 1, holding at all-ones.
//   If E==5 and is_load_PC=1, pc <= pc+1.
//  Illegal cycle: no ack, no pc or retired update. If proto_err==0: proto_err<=1 and
//   err_state<=E. Later errors leave err_state unchanged.
//   Resync: exactly one open strobe k high -> expect_state <= k+1. No open strobe
//   high and is_load_PC=1 -> expect_state <= 0. Otherwise the normal advance applies.
//  halted: updated every cycle from the post-update pc (pc_next >= INSTRUCTION_NUMBERS).
//  pc wrap: impossible by construction, since pc stops at INSTRUCTION_NUMBERS.
//  No combinational path from inputs to outputs. All outputs are registered.
// TESTING
//  1 Reset, drive a legal 6-cycle loop -> stage_ack pulses 1,2,4,8 on cycles 1..4;
//    pc 0->1 after the LOAD_PC edge; retired_cnt=1; proto_err=0.
//  2 Run 16 legal loops (N=16) -> pc=16, halted=1, retired_cnt=16. A 17th LOAD_PC with
//    is_load_PC=0 -> no error and pc stays 16.
//  3 At E=1, drive is_IDEX_open and is_EXMEM_open together -> proto_err=1, err_state=1,
//    no ack, expect_state=2.
//  4 At E=0, drive is_EXMEM_open only -> proto_err=1, err_state=0, expect_state=3.
//    A later error keeps err_state=0.
//  5 At E=5 with pc=3, drive is_load_PC=0 -> proto_err=1, pc stays 3, expect_state=0.
//  6 CNT_WIDTH=2: 5 legal loops -> retired_cnt saturates at 3. Assert rst mid-EX_MEM ->
//    all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/conveer_stage_if.sv
// Stage-strobe bus between the conveer control FSM (master) and the stage responder (slave).
interface conveer_stage_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 is_IFID_open;
  logic                 is_IDEX_open;
  logic                 is_EXMEM_open;
  logic                 is_MEMWB_open;
  logic                 is_load_PC;
  logic [WIDTH-1:0]     pc;
  logic [3:0]           stage_ack;
  logic [2:0]           expect_state;
  logic [CNT_WIDTH-1:0] retired_cnt;
  logic                 halted;
  logic                 proto_err;
  logic [2:0]           err_state;

  modport master (
    output is_IFID_open, is_IDEX_open, is_EXMEM_open, is_MEMWB_open, is_load_PC,
    input  pc, stage_ack, expect_state, retired_cnt, halted, proto_err, err_state
  );

  modport slave (
    input  is_IFID_open, is_IDEX_open, is_EXMEM_open, is_MEMWB_open, is_load_PC,
    output pc, stage_ack, expect_state, retired_cnt, halted, proto_err, err_state
  );
endinterface

// File: rtl/conveer_stage_responder.sv
// Receiving end of the conveer stage-strobe bus: tracks the stage sequence, acks strobes,
// owns the PC, counts retired instructions and flags protocol violations.
//
// state   | meaning
// IF_ID   | expecting is_IFID_open alone
// ID_EX   | expecting is_IDEX_open alone
// EX_MEM  | expecting is_EXMEM_open alone
// MEM_WB  | expecting is_MEMWB_open alone (retires an instruction)
// WRITE   | expecting all inputs idle
// LOAD_PC | expecting is_load_PC exactly when pc < INSTRUCTION_NUMBERS
module conveer_stage_responder #(
  parameter int WIDTH               = 32,
  parameter int INSTRUCTION_NUMBERS = 16,
  parameter int CNT_WIDTH           = 16
) (
  input logic            clk,
  input logic            rst,
  conveer_stage_if.slave bus
);
  typedef enum logic [2:0] {
    IF_ID   = 3'd0,
    ID_EX   = 3'd1,
    EX_MEM  = 3'd2,
    MEM_WB  = 3'd3,
    WRITE   = 3'd4,
    LOAD_PC = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0] PC_LIMIT = WIDTH'(INSTRUCTION_NUMBERS);

  state_t               state_q, state_d, advance;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [3:0]           ack_q, ack_d;
  logic [CNT_WIDTH-1:0] ret_q, ret_d;
  logic                 halted_q, halted_d;
  logic                 err_q, err_d;
  logic [2:0]           err_state_q, err_state_d;
  logic [3:0]           strobes;
  logic                 ld;
  logic                 can_load;
  logic                 legal;

  assign strobes  = {bus.is_MEMWB_open, bus.is_EXMEM_open, bus.is_IDEX_open, bus.is_IFID_open};
  assign ld       = bus.is_load_PC;
  assign can_load = (pc_q < PC_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IF_ID;
      pc_q        <= '0;
      ack_q       <= '0;
      ret_q       <= '0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      err_state_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ack_q       <= ack_d;
      ret_q       <= ret_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      err_state_q <= err_state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ack_d       = '0;
    ret_d       = ret_q;
    err_d       = err_q;
    err_state_d = err_state_q;
    legal       = 1'b0;
    advance     = (state_q >= LOAD_PC) ? IF_ID : state_t'(state_q + 3'd1);

    case (state_q)
      IF_ID:   legal = (strobes == 4'b0001) && !ld;
      ID_EX:   legal = (strobes == 4'b0010) && !ld;
      EX_MEM:  legal = (strobes == 4'b0100) && !ld;
      MEM_WB:  legal = (strobes == 4'b1000) && !ld;
      WRITE:   legal = (strobes == 4'b0000) && !ld;
      LOAD_PC: legal = (strobes == 4'b0000) && (ld == can_load);
      default: legal = 1'b0;
    endcase

    if (legal) begin
      state_d = advance;
      case (state_q)
        IF_ID:   ack_d = 4'b0001;
        ID_EX:   ack_d = 4'b0010;
        EX_MEM:  ack_d = 4'b0100;
        MEM_WB: begin
          ack_d = 4'b1000;
          if (ret_q != '1) ret_d = ret_q + 1'b1;
        end
        LOAD_PC: if (ld) pc_d = pc_q + 1'b1;
        default: ;
      endcase
    end else begin
      if (!err_q) begin
        err_d       = 1'b1;
        err_state_d = state_q;
      end
      // Resync onto whatever stage the master appears to be in.
      case (strobes)
        4'b0001: state_d = ID_EX;
        4'b0010: state_d = EX_MEM;
        4'b0100: state_d = MEM_WB;
        4'b1000: state_d = WRITE;
        4'b0000: state_d = ld ? IF_ID : advance;
        default: state_d = advance;
      endcase
    end

    halted_d = (pc_d >= PC_LIMIT);
  end

  assign bus.pc           = pc_q;
  assign bus.stage_ack    = ack_q;
  assign bus.expect_state = state_q;
  assign bus.retired_cnt  = ret_q;
  assign bus.halted       = halted_q;
  assign bus.proto_err    = err_q;
  assign bus.err_state    = err_state_q;
endmodule
